// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source: turns timing-controller counters into registered RGB
// with syncs and data-enable re-aligned to the same two-cycle pipeline latency.
module vga_pattern_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned H_OFFSET   = 144,
    parameter int unsigned V_OFFSET   = 35,
    parameter int unsigned COLOR_BITS = 4,
    parameter int unsigned BOX_SIZE   = 32
) (
    input  logic                  clock_in,
    input  logic                  reset,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic [31:0]           hpixel_in,
    input  logic [31:0]           line_in,
    input  logic                  active_in,
    input  logic [1:0]            mode,
    output logic [COLOR_BITS-1:0] red,
    output logic [COLOR_BITS-1:0] green,
    output logic [COLOR_BITS-1:0] blue,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  de_out,
    output logic [15:0]           frame_count,
    output logic [1:0]            active_mode
);

    localparam int unsigned CW    = 11;
    localparam int unsigned BAR_W = H_ACTIVE / 8;
    localparam logic [CW-1:0] X_MAX = CW'(H_ACTIVE - BOX_SIZE);
    localparam logic [CW-1:0] Y_MAX = CW'(V_ACTIVE - BOX_SIZE);
    localparam logic [COLOR_BITS-1:0] C_ON = '1;

    logic [CW-1:0] x_d, y_d, x_q, y_q;
    logic          act1_q, hs1_q, vs1_q;
    logic          vs_prev_q;
    logic          tick_c;
    logic [CW-1:0] box_x_d, box_x_q, box_y_d, box_y_q;
    logic          dx_neg_d, dx_neg_q, dy_neg_d, dy_neg_q;
    logic          in_frame_c, in_box_c;
    logic [2:0]    bar_c;
    logic [COLOR_BITS-1:0] ramp_c;
    logic [COLOR_BITS-1:0] r_d, g_d, b_d;

    // Stage 1: screen-relative coordinates
    always_comb begin
        x_d = CW'(hpixel_in - 32'(H_OFFSET));
        y_d = CW'(line_in - 32'(V_OFFSET));
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            x_q    <= '0;
            y_q    <= '0;
            act1_q <= 1'b0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            act1_q <= active_in;
            hs1_q  <= hsync_in;
            vs1_q  <= vsync_in;
        end
    end

    // Frame tick on the falling edge of vsync; prev resets low so no tick right after reset
    assign tick_c = vs_prev_q & ~vsync_in;

    always_comb begin
        box_x_d  = box_x_q;
        box_y_d  = box_y_q;
        dx_neg_d = dx_neg_q;
        dy_neg_d = dy_neg_q;
        if (tick_c) begin
            if (!dx_neg_q && box_x_q == X_MAX) begin
                dx_neg_d = 1'b1;
                box_x_d  = box_x_q - CW'(1);
            end else if (dx_neg_q && box_x_q == '0) begin
                dx_neg_d = 1'b0;
                box_x_d  = CW'(1);
            end else begin
                box_x_d  = dx_neg_q ? box_x_q - CW'(1) : box_x_q + CW'(1);
            end

            if (!dy_neg_q && box_y_q == Y_MAX) begin
                dy_neg_d = 1'b1;
                box_y_d  = box_y_q - CW'(1);
            end else if (dy_neg_q && box_y_q == '0) begin
                dy_neg_d = 1'b0;
                box_y_d  = CW'(1);
            end else begin
                box_y_d  = dy_neg_q ? box_y_q - CW'(1) : box_y_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            vs_prev_q   <= 1'b0;
            box_x_q     <= '0;
            box_y_q     <= '0;
            dx_neg_q    <= 1'b0;
            dy_neg_q    <= 1'b0;
            frame_count <= '0;
            active_mode <= '0;
        end else begin
            vs_prev_q <= vsync_in;
            box_x_q   <= box_x_d;
            box_y_q   <= box_y_d;
            dx_neg_q  <= dx_neg_d;
            dy_neg_q  <= dy_neg_d;
            if (tick_c) begin
                frame_count <= frame_count + 16'd1;
                active_mode <= mode;
            end
        end
    end

    // Stage 2: pattern colour; bar index bits map directly onto inverted RGB enables
    always_comb begin
        in_frame_c = act1_q && (x_q < CW'(H_ACTIVE)) && (y_q < CW'(V_ACTIVE));
        in_box_c   = (x_q >= box_x_q) && (x_q < box_x_q + CW'(BOX_SIZE)) &&
                     (y_q >= box_y_q) && (y_q < box_y_q + CW'(BOX_SIZE));
        bar_c      = 3'(x_q / CW'(BAR_W));
        ramp_c     = x_q[COLOR_BITS+4:5];
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (in_frame_c) begin
            case (active_mode)
                2'd0: begin
                    r_d = {COLOR_BITS{~bar_c[1]}};
                    g_d = {COLOR_BITS{~bar_c[2]}};
                    b_d = {COLOR_BITS{~bar_c[0]}};
                end
                2'd1: begin
                    r_d = {COLOR_BITS{x_q[5] ^ y_q[5]}};
                    g_d = {COLOR_BITS{x_q[5] ^ y_q[5]}};
                    b_d = {COLOR_BITS{x_q[5] ^ y_q[5]}};
                end
                2'd2: begin
                    r_d = in_box_c ? C_ON : '0;
                    g_d = in_box_c ? C_ON : '0;
                    b_d = C_ON;
                end
                default: begin
                    r_d = ramp_c;
                    g_d = ramp_c;
                    b_d = ramp_c;
                end
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
            de_out    <= 1'b0;
        end else begin
            red       <= r_d;
            green     <= g_d;
            blue      <= b_d;
            hsync_out <= hs1_q;
            vsync_out <= vs1_q;
            de_out    <= act1_q;
        end
    end

endmodule
